inv_sub_bytes_seq: RTL

Sequential InvSubBytes engine for the decryption datapath. It is the inverse of the 32-bit composite-field SubBytes stage. Each 32-bit state column is processed LANES bytes per cycle: inverse affine transform, then GF(2^8) multiplicative inverse (the existing GF_MULINV_8 instance, one per lane). The block uses a valid/ready handshake on both sides and sits between InvShiftRows and AddRoundKey in the iterative decryption round.

---
 rtl/inv_sub_bytes_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes engine: inverse affine transform followed by the GF(2^8)
// multiplicative inverse, LANES bytes per cycle, with valid/ready on both sides.

module gf_mulinv_8 (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] pw;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ acc;
      acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the inverse in GF(2^8) and naturally maps 0 to 0
  always_comb begin
    pw = a;
    for (int i = 0; i < 6; i++) pw = gf_mul(gf_mul(pw, pw), a);
    y = gf_mul(pw, pw);
  end

endmodule

module inv_sub_bytes_seq #(
  parameter int LANES  = 1,
  parameter int NBYTES = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] din,
  input  logic        din_vld,
  output logic        din_rdy,
  output logic [31:0] dout,
  output logic        dout_vld,
  input  logic        dout_rdy,
  output logic        busy
);

  localparam int NGROUPS = NBYTES / LANES;
  localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int GW      = LANES * 8;

  localparam logic [1:0]    IDLE = 2'd0;
  localparam logic [1:0]    BUSY = 2'd1;
  localparam logic [1:0]    DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(NGROUPS - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2 or 4");
    end
    if (NBYTES != 4) begin : g_bad_nbytes
      $error("inv_sub_bytes_seq: NBYTES is fixed at 4");
    end
  endgenerate

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   word_q;
  logic [31:0]   dout_q;
  logic          dout_vld_q;
  logic [GW-1:0] group_in;
  logic [GW-1:0] group_out;
  logic [31:0]   dout_next;

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 0; i < 8; i++) t[i] = s[(i + 2) % 8] ^ s[(i + 5) % 8] ^ s[(i + 7) % 8];
    return t ^ 8'h05;
  endfunction

  // cnt selects which lane group of the latched word is processed this cycle;
  // only that group of the output register is replaced
  generate
    if (NGROUPS == 1) begin : g_one_group
      assign group_in  = word_q;
      assign dout_next = group_out;
    end else begin : g_multi_group
      logic [NGROUPS-1:0][GW-1:0] word_slots;
      logic [NGROUPS-1:0][GW-1:0] dout_slots;
      assign word_slots = word_q;
      assign group_in   = word_slots[cnt];
      always_comb begin
        dout_slots      = dout_q;
        dout_slots[cnt] = group_out;
      end
      assign dout_next = dout_slots;
    end
  endgenerate

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] aff;
    assign aff = inv_affine(group_in[l*8 +: 8]);
    gf_mulinv_8 u_inv (
      .a (aff),
      .y (group_out[l*8 +: 8])
    );
  end

  assign busy     = (state == BUSY);
  assign din_rdy  = (state == IDLE) || ((state == DONE) && dout_rdy);
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

  // DONE accepts a new word in the same cycle the result is taken, so
  // back-to-back words leave no idle cycle between them
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      cnt        <= '0;
      word_q     <= 32'h0;
      dout_q     <= 32'h0;
      dout_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (din_vld) begin
            word_q <= din;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          dout_q <= dout_next;
          if (cnt == LAST) begin
            dout_vld_q <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (dout_rdy) begin
            dout_vld_q <= 1'b0;
            if (din_vld) begin
              word_q <= din;
              cnt    <= '0;
              state  <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          dout_vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
